// File: rtl/key_bounce_gen_if.sv
// key_bounce_gen_if
//   Request/response bundle for the bouncing key generator.
//   master : requester side (drives req_valid/req_press, observes the rest)
//   slave  : generator side (key_bounce_gen)
//   Signals:
//     req_valid  request strobe
//     req_press  requested level, 1 = press (key_n low), 0 = release
//     req_ready  generator idle and able to accept a request
//     key_n      raw bouncing key, active-low, idle high
//     busy       burst or settle hold in progress
//     done       one-cycle completion pulse
interface key_bounce_gen_if;
  logic req_valid;
  logic req_press;
  logic req_ready;
  logic key_n;
  logic busy;
  logic done;

  modport master (
    output req_valid, req_press,
    input  req_ready, key_n, busy, done
  );

  modport slave (
    input  req_valid, req_press,
    output req_ready, key_n, busy, done
  );
endinterface

// File: rtl/key_bounce_gen.sv
// key_bounce_gen
//   Produces the raw, bouncing, active-low waveform of a push-button for
//   self-test/loopback of the debounce path. Each accepted request gives one
//   clean first edge, 2*N_BOUNCE pseudo-random bounce toggles, then a settled
//   hold of SETTLE_CYC cycles followed by a one-cycle done pulse.
//   Ports:
//     clk  system clock
//     rst  asynchronous, active-high reset
//     bus  key_bounce_gen_if.slave (req_valid, req_press, req_ready,
//          key_n, busy, done)
module key_bounce_gen #(
  parameter int          N_BOUNCE   = 5,
  parameter int          BOUNCE_W   = 10,
  parameter int          SETTLE_CYC = 240000,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  key_bounce_gen_if.slave   bus
);

  // An all-zero Galois LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [15:0] SEED  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  // One extra bit so the largest interval (2^BOUNCE_W) fits without wrapping.
  localparam int          IVL_W = BOUNCE_W + 1;
  localparam int          SET_W = $clog2(SETTLE_CYC + 1);
  localparam int          TGL_W = (N_BOUNCE < 1) ? 1 : $clog2(2 * N_BOUNCE + 1);

  localparam logic [SET_W-1:0] SETTLE_LD = SET_W'(SETTLE_CYC);
  localparam logic [TGL_W-1:0] TGL_LD    = TGL_W'(2 * N_BOUNCE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BOUNCE,
    S_SETTLE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              key_n_q, key_n_d;
  logic [15:0]       lfsr_q,  lfsr_d;
  logic [IVL_W-1:0]  ivl_q,   ivl_d;
  logic [TGL_W-1:0]  tgl_q,   tgl_d;
  logic [SET_W-1:0]  set_q,   set_d;

  // 16-bit Galois LFSR, right shift, taps 0xB400.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  // Bounce interval 1..2^BOUNCE_W taken from the low LFSR bits.
  function automatic logic [IVL_W-1:0] ivl_from(input logic [15:0] v);
    return IVL_W'(v[BOUNCE_W-1:0]) + IVL_W'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      key_n_q <= 1'b1;
      lfsr_q  <= SEED;
      ivl_q   <= '0;
      tgl_q   <= '0;
      set_q   <= '0;
    end else begin
      state_q <= state_d;
      key_n_q <= key_n_d;
      lfsr_q  <= lfsr_d;
      ivl_q   <= ivl_d;
      tgl_q   <= tgl_d;
      set_q   <= set_d;
    end
  end

  always_comb begin
    state_d = state_q;
    key_n_d = key_n_q;
    lfsr_d  = lfsr_q;
    ivl_d   = ivl_q;
    tgl_d   = tgl_q;
    set_d   = set_q;

    case (state_q)
      S_IDLE: begin
        // req_ready is high throughout IDLE, so req_valid alone fires.
        if (bus.req_valid) begin
          if ((!bus.req_press) == key_n_q) begin
            // Already at the requested level: hold only, no edge.
            state_d = S_SETTLE;
            set_d   = SETTLE_LD;
          end else begin
            key_n_d = !bus.req_press;
            if (N_BOUNCE == 0) begin
              state_d = S_SETTLE;
              set_d   = SETTLE_LD;
            end else begin
              tgl_d   = TGL_LD;
              ivl_d   = ivl_from(lfsr_q);
              lfsr_d  = lfsr_next(lfsr_q);
              state_d = S_BOUNCE;
            end
          end
        end
      end

      S_BOUNCE: begin
        // Counter at 1 means this edge is exactly I cycles after the last one.
        if (ivl_q == IVL_W'(1)) begin
          key_n_d = !key_n_q;
          tgl_d   = tgl_q - TGL_W'(1);
          if (tgl_q != TGL_W'(1)) begin
            ivl_d  = ivl_from(lfsr_q);
            lfsr_d = lfsr_next(lfsr_q);
          end else begin
            ivl_d   = '0;
            state_d = S_SETTLE;
            set_d   = SETTLE_LD;
          end
        end else begin
          ivl_d = ivl_q - IVL_W'(1);
        end
      end

      S_SETTLE: begin
        set_d = set_q - SET_W'(1);
        if (set_q == SET_W'(1)) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status outputs decode state only; key_n comes straight from its flop.
  assign bus.key_n     = key_n_q;
  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.busy      = (state_q == S_BOUNCE) || (state_q == S_SETTLE);
  assign bus.done      = (state_q == S_DONE);

endmodule

// File: tb/tb_key_bounce_gen.sv
module tb_key_bounce_gen;

  localparam int S    = 16;
  localparam int NB_A = 2;
  localparam int BW   = 10;

  logic clk = 1'b0;
  logic rst;
  logic req_valid;
  logic req_press;
  bit   sel;

  always #5 clk = ~clk;

  key_bounce_gen_if if_a ();
  key_bounce_gen_if if_b ();

  assign if_a.req_valid = req_valid & ~sel;
  assign if_a.req_press = req_press;
  assign if_b.req_valid = req_valid & sel;
  assign if_b.req_press = req_press;

  key_bounce_gen #(
    .N_BOUNCE   (NB_A),
    .BOUNCE_W   (BW),
    .SETTLE_CYC (S),
    .LFSR_SEED  (16'hACE1)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a)
  );

  key_bounce_gen #(
    .N_BOUNCE   (0),
    .BOUNCE_W   (BW),
    .SETTLE_CYC (S),
    .LFSR_SEED  (16'h0000)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b)
  );

  logic key_n_s, ready_s, busy_s, done_s;
  assign key_n_s = sel ? if_b.key_n     : if_a.key_n;
  assign ready_s = sel ? if_b.req_ready : if_a.req_ready;
  assign busy_s  = sel ? if_b.busy      : if_a.busy;
  assign done_s  = sel ? if_b.done      : if_a.done;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: per-DUT LFSR state and settled key level.
  logic [15:0] m_lfsr [2];
  bit          m_key  [2];

  function automatic logic [15:0] ref_step(input logic [15:0] v);
    if ((v % 2) == 1) return (v / 2) ^ 16'hB400;
    return v / 2;
  endfunction

  task automatic model_reset();
    m_lfsr[0] = 16'hACE1;
    m_lfsr[1] = 16'h0001;
    m_key[0]  = 1'b1;
    m_key[1]  = 1'b1;
  endtask

  int got_edges[$];

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // One request: build the expected edge list and done time from the model,
  // then watch the selected DUT cycle by cycle (edge offsets relative to the
  // handshake edge). noise=1 throws random requests at the busy DUT.
  task automatic do_req(input bit press, input bit noise, input int gap);
    int  exp_edges[$];
    int  t, last, exp_done, nb, done_cnt, done_at, busy_cnt, ready_in_done;
    bit  tgt, prev;
    nb  = sel ? 0 : NB_A;
    tgt = !press;
    if (tgt != m_key[sel]) begin
      exp_edges.push_back(0);
      t = 0;
      for (int i = 0; i < 2 * nb; i++) begin
        t += int'(m_lfsr[sel] % (2 ** BW)) + 1;
        m_lfsr[sel] = ref_step(m_lfsr[sel]);
        exp_edges.push_back(t);
      end
      m_key[sel] = tgt;
    end
    last     = (exp_edges.size() > 0) ? exp_edges[exp_edges.size() - 1] : 0;
    exp_done = last + S;

    repeat (gap) @(negedge clk);
    @(negedge clk);
    check_eq("ready_idle", int'(ready_s), 1);
    prev      = key_n_s;
    req_valid = 1'b1;
    req_press = press;
    got_edges.delete();
    done_cnt      = 0;
    done_at       = -1;
    busy_cnt      = 0;
    ready_in_done = -1;
    for (int r = 0; r <= exp_done + 1; r++) begin
      @(negedge clk);
      if (noise && r < exp_done && $urandom_range(0, 3) == 0) begin
        req_valid = 1'b1;
        req_press = 1'($urandom);
      end else begin
        req_valid = 1'b0;
      end
      if (key_n_s !== prev) begin
        got_edges.push_back(r);
        prev = key_n_s;
      end
      if (done_s) begin
        done_cnt++;
        done_at = r;
      end
      if (busy_s) busy_cnt++;
      if (r == exp_done) ready_in_done = int'(ready_s);
    end
    req_valid = 1'b0;

    check_eq("ready_after_done", int'(ready_s), 1);
    check_eq("ready_in_done", ready_in_done, 0);
    check_eq("edge_count", got_edges.size(), exp_edges.size());
    for (int i = 0; i < exp_edges.size() && i < got_edges.size(); i++)
      check_eq("edge_time", got_edges[i], exp_edges[i]);
    check_eq("key_final", int'(key_n_s), int'(m_key[sel]));
    check_eq("done_pulses", done_cnt, 1);
    check_eq("done_at", done_at, exp_done);
    check_eq("busy_cycles", busy_cnt, exp_done);
  endtask

  task automatic check_first_intervals();
    check_eq("edge1_at_226", (got_edges.size() > 1) ? got_edges[1] : -1, 226);
    check_eq("edge2_at_851", (got_edges.size() > 2) ? got_edges[2] : -1, 851);
  endtask

  initial begin
    #900000;
    $display("FAIL timeout: got %0d expected %0d", 0, 1);
    $fatal(1, "simulation time limit");
  end

  initial begin
    sel       = 1'b0;
    req_valid = 1'b0;
    req_press = 1'b0;
    rst       = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("rst_key_n_a", int'(if_a.key_n), 1);
    check_eq("rst_key_n_b", int'(if_b.key_n), 1);
    check_eq("rst_ready", int'(if_a.req_ready), 1);
    check_eq("rst_busy", int'(if_a.busy), 0);
    check_eq("rst_done", int'(if_a.done), 0);
    rst = 1'b0;

    // Default-seed press: 5 edges, first intervals 226 then 625.
    do_req(1'b1, 1'b0, 2);
    check_first_intervals();
    // Redundant press: no edge, busy for S cycles.
    do_req(1'b1, 1'b0, 3);
    do_req(1'b0, 1'b0, 1);

    // Same press after reset, with ignored requests during the burst.
    pulse_reset();
    do_req(1'b1, 1'b1, 2);
    check_first_intervals();

    // Reset mid-BOUNCE, then the burst must repeat from the seed.
    pulse_reset();
    @(negedge clk);
    req_valid = 1'b1;
    req_press = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (100) @(negedge clk);
    check_eq("mid_busy", int'(if_a.busy), 1);
    check_eq("mid_key_n", int'(if_a.key_n), 0);
    #2 rst = 1'b1;
    #1;
    check_eq("async_key_n", int'(if_a.key_n), 1);
    check_eq("async_ready", int'(if_a.req_ready), 1);
    check_eq("async_busy", int'(if_a.busy), 0);
    check_eq("async_done", int'(if_a.done), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    do_req(1'b1, 1'b0, 1);
    check_first_intervals();

    // Randomized requests against the model.
    for (int k = 0; k < 10; k++) begin
      if ($urandom_range(0, 4) == 0) pulse_reset();
      do_req(1'($urandom), 1'($urandom), $urandom_range(0, 5));
    end

    // N_BOUNCE=0 instance: single clean edges.
    sel = 1'b1;
    do_req(1'b1, 1'b0, 1);
    do_req(1'b0, 1'b0, 2);
    do_req(1'b0, 1'b1, 1);
    do_req(1'b1, 1'b1, 0);
    sel = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/key_bounce_gen.md
Name: key_bounce_gen

Overview:
- Synthesizable generator for the raw, bouncing, active-low key waveform that a push-button produces.
- It is the transmit side of the key interface: it produces the kind of waveform the board-level debouncers consume.
- Used for on-board self-test and loopback of the debounce/LED-toggle path: key_n is fed straight into a debouncer input.
- Each accepted press/release request produces one clean first edge, a pseudo-random burst of bounce toggles, then a settled hold period.

Parameters:
- N_BOUNCE, 5: bounce pairs after the first edge; total edges per event = 1 + 2*N_BOUNCE; 0 gives a single clean edge.
- BOUNCE_W, 10: width of the random bounce-interval field; interval range 1..2^BOUNCE_W cycles.
- SETTLE_CYC, 240000: settled hold after the final edge (20 ms at 12 MHz); must be >= 1.
- LFSR_SEED, 16'hACE1: LFSR reset value; a value of 0 is replaced by 16'h0001.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request strobe.
- req_press  input  1  requested level: 1 = press (key_n low), 0 = release (key_n high); sampled with req_valid.
- req_ready  output  1  high only in IDLE.
- key_n  output  1  registered raw key, active-low, idle high.
- busy  output  1  high in BOUNCE and SETTLE.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (async, immediate, including mid-operation):
  - key_n=1, req_ready=1, busy=0, done=0.
  - lfsr=LFSR_SEED (or 1 if the seed is 0); all counters 0; state IDLE.
- States: IDLE, BOUNCE, SETTLE, DONE.
- LFSR: 16-bit Galois, right shift. If lsb=1, next = (lfsr>>1)^16'hB400; else next = lfsr>>1. It advances only on interval loads (defined below).
- IDLE:
  - req_ready=1.
  - Handshake fires on the edge where req_valid & req_ready; target = ~req_press.
  - If target == key_n: no edge; go to SETTLE, settle counter starts.
  - Else, on that same edge:
    - key_n <= target;
    - if N_BOUNCE=0, go to SETTLE;
    - otherwise set toggles_left = 2*N_BOUNCE, load interval I = lfsr[BOUNCE_W-1:0]+1, advance lfsr, and go to BOUNCE.
- BOUNCE:
  - Interval counter decrements each cycle; key_n toggles exactly I cycles after the previous edge.
  - On each toggle, toggles_left decrements.
  - If toggles_left is still nonzero after decrement, reload I from the current lfsr and advance lfsr.
  - When toggles_left reaches 0, key_n == target; go to SETTLE.
- SETTLE:
  - key_n held constant for exactly SETTLE_CYC cycles after the final edge (or after the handshake edge if there was no edge).
  - Then go to DONE.
- DONE:
  - done=1 for exactly one cycle; busy=0, req_ready=0.
  - Next cycle goes to IDLE.
- Request handling outside IDLE:
  - req_valid is ignored whenever req_ready=0; no queuing, no effect on key_n, lfsr or timing.
  - req_press is don't-care when req_valid=0.
- Counter widths:
  - Interval counter is BOUNCE_W+1 bits (holds 2^BOUNCE_W without overflow).
  - Settle counter is wide enough for SETTLE_CYC.
  - toggles_left wide enough for 2*N_BOUNCE.
  - No wrap-around is permitted.
- Determinism: after reset, the interval sequence is fixed by LFSR_SEED. With the defaults, the first intervals are 226 (seed low bits 0x0E1) and then 625 (lfsr=16'hE270, low bits 0x270).
- Glitch freedom: key_n is driven directly from a flop; busy, done and req_ready are decoded only from state.

Test Plan:
- Reset: assert rst mid-run -> key_n=1, req_ready=1, busy=0, done=0 immediately, without waiting for a clock.
- Press with N_BOUNCE=2, SETTLE_CYC=16, default seed; handshake at edge 0 ->
  - key_n 1->0 at edge 0, 0->1 at edge 226, 1->0 at edge 851;
  - two further toggles using the next lfsr values; exactly 5 edges total, final key_n=0;
  - done high for 1 cycle 16 cycles after the last edge, req_ready=1 the cycle after.
- Redundant request: press while key_n=0 -> no key_n edge; busy for 16 cycles, then one done pulse.
- Request while busy: pulse req_valid with req_press=0 during BOUNCE -> ignored; waveform and done timing identical to the press scenario.
- Reset mid-BOUNCE then press again -> key_n=1 at reset; the new burst repeats the 226/625 interval sequence exactly.
- N_BOUNCE=0, release after press -> a single 0->1 edge at the handshake edge; done pulse SETTLE_CYC cycles later; loopback into the debouncer toggles led exactly once per press.
